// File: rtl/sensor_feature_acc_if.sv
// Sample-stream and feature-vector handshake bundle for sensor_feature_acc.
// master: the sample source / feature consumer; slave: the accumulator block.
interface sensor_feature_acc_if #(
    parameter int DIMS  = 6,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic                         s_valid_i;
    logic                         s_ready_o;
    logic [IN_W-1:0]              s_data_i;
    logic                         s_last_i;
    logic [DIMS-1:0][OUT_W-1:0]   feat_o;
    logic                         feat_valid_o;
    logic                         feat_ready_i;

    modport master (
        output s_valid_i, s_data_i, s_last_i, feat_ready_i,
        input  s_ready_o, feat_o, feat_valid_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, feat_ready_i,
        output s_ready_o, feat_o, feat_valid_o
    );
endinterface

// File: rtl/sensor_feature_acc.sv
// Per-channel windowed averager with baseline subtraction feeding the LDA
// classifier. Samples arrive one channel per beat; every 2^LOG2_AVG frames the
// averages either become the new baseline (CAL) or, minus the baseline and
// clamped at zero, the presented feature vector (RUN).
module sensor_feature_acc #(
    parameter int DIMS     = 6,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int LOG2_AVG = 3
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    sensor_feature_acc_if.slave  bus,
    input  logic                 calibrate_i,
    output logic                 cal_busy_o,
    output logic                 err_o
);
    localparam int AW = IN_W + LOG2_AVG;
    localparam int CW = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int WW = (IN_W > OUT_W) ? IN_W + 1 : OUT_W + 1;
    localparam logic [WW-1:0] SAT_MAX = {{(WW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic {ST_RUN, ST_CAL} state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_ch;
    logic [LOG2_AVG-1:0]         r_frame;
    logic [AW-1:0]               r_acc  [DIMS];
    logic [IN_W-1:0]             r_base [DIMS];
    logic [DIMS-1:0][OUT_W-1:0]  r_feat;
    logic                        r_feat_valid;
    logic                        r_err;
    logic                        r_cal_busy;

    logic                        w_last_ch;
    logic                        w_final;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_frame_err;
    logic [AW-1:0]               w_sum  [DIMS];
    logic [IN_W-1:0]             w_avg  [DIMS];
    logic [WW-1:0]               w_diff [DIMS];
    logic [DIMS-1:0][OUT_W-1:0]  w_feat;

    assign w_last_ch   = (r_ch == CW'(DIMS - 1));
    assign w_final     = w_last_ch && (&r_frame);
    // Only the window-completing beat waits for an unaccepted vector.
    assign w_ready     = !(r_feat_valid && !bus.feat_ready_i && (r_state == ST_RUN) && w_final);
    assign w_accept    = bus.s_valid_i && w_ready;
    assign w_frame_err = w_accept && (bus.s_last_i != w_last_ch);

    assign bus.s_ready_o    = w_ready;
    assign bus.feat_o       = r_feat;
    assign bus.feat_valid_o = r_feat_valid;
    assign cal_busy_o       = r_cal_busy;
    assign err_o            = r_err;

    // Running sums including the current beat, their averages and clamped features.
    always_comb begin
        for (int unsigned i = 0; i < DIMS; i++) begin
            w_sum[i] = r_acc[i];
            if (CW'(i) == r_ch) begin
                w_sum[i] = r_acc[i] + AW'(bus.s_data_i);
            end
            w_avg[i]  = w_sum[i][AW-1:LOG2_AVG];
            w_diff[i] = '0;
            if (w_avg[i] > r_base[i]) begin
                w_diff[i] = WW'(w_avg[i] - r_base[i]);
            end
            if (w_diff[i] > SAT_MAX) begin
                w_feat[i] = '1;
            end else begin
                w_feat[i] = w_diff[i][OUT_W-1:0];
            end
        end
    end

    // Mode FSM, counters, accumulators, baselines and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_RUN;
            r_ch         <= '0;
            r_frame      <= '0;
            r_feat       <= '0;
            r_feat_valid <= 1'b0;
            r_err        <= 1'b0;
            r_cal_busy   <= 1'b0;
            for (int unsigned i = 0; i < DIMS; i++) begin
                r_acc[i]  <= '0;
                r_base[i] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            // A completing RUN window below may re-raise valid in the same cycle.
            if (r_feat_valid && bus.feat_ready_i) begin
                r_feat_valid <= 1'b0;
            end
            if (calibrate_i) begin
                r_state    <= ST_CAL;
                r_cal_busy <= 1'b1;
                r_ch       <= '0;
                r_frame    <= '0;
                for (int unsigned i = 0; i < DIMS; i++) begin
                    r_acc[i] <= '0;
                end
            end else if (w_accept) begin
                if (w_frame_err || w_final) begin
                    r_ch    <= '0;
                    r_frame <= '0;
                    for (int unsigned i = 0; i < DIMS; i++) begin
                        r_acc[i] <= '0;
                    end
                end
                if (w_frame_err) begin
                    r_err <= 1'b1;
                end else if (w_final) begin
                    if (r_state == ST_RUN) begin
                        r_feat       <= w_feat;
                        r_feat_valid <= 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < DIMS; i++) begin
                            r_base[i] <= w_avg[i];
                        end
                        r_state    <= ST_RUN;
                        r_cal_busy <= 1'b0;
                    end
                end else begin
                    // w_sum already equals r_acc for every channel but the current one.
                    for (int unsigned i = 0; i < DIMS; i++) begin
                        r_acc[i] <= w_sum[i];
                    end
                    if (w_last_ch) begin
                        r_ch    <= '0;
                        r_frame <= r_frame + 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sensor_feature_acc.sv
// Self-checking bench for sensor_feature_acc: a window-level model predicts
// feature vectors, calibration state and error pulses; directed tests add
// hand-computed literal expectations.
module tb_sensor_feature_acc;
    localparam int DIMS = 6, IN_W = 16, OUT_W = 16, LOG2_AVG = 3, NF = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic calibrate = 1'b0;
    logic cal_busy, err;

    int checks = 0;
    int errors = 0;

    // Window-level reference state.
    bit                         m_pend = 0;
    bit                         m_cal  = 0;
    bit                         m_err  = 0;
    logic [DIMS-1:0][OUT_W-1:0] m_vec  = '0;
    int unsigned                m_base [DIMS];
    int unsigned                win [NF][DIMS];

    int beat_no = 0;
    int release_after = 0;
    int stall_log[$];

    always #5 clk = ~clk;

    sensor_feature_acc_if #(.DIMS(DIMS), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sensor_feature_acc #(.DIMS(DIMS), .IN_W(IN_W), .OUT_W(OUT_W), .LOG2_AVG(LOG2_AVG)) dut (
        .clk_i       (clk),
        .rstn_i      (rst_n),
        .bus         (bus),
        .calibrate_i (calibrate),
        .cal_busy_o  (cal_busy),
        .err_o       (err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("feat_valid", bus.feat_valid_o, m_pend);
            if (m_pend) chk("feat_vec", bus.feat_o, m_vec);
            chk("cal_busy", cal_busy, m_cal);
            chk("err", err, m_err);
            if (m_pend && bus.feat_ready_i) m_pend = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic send_beat(input int unsigned d, input bit last);
        int n = 0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = IN_W'(d);
        bus.s_last_i  = last;
        @(negedge clk);
        while (!bus.s_ready_o && n < 200) begin
            if (n == 0) stall_log.push_back(beat_no + 1);
            n++;
            if (release_after != 0 && n == release_after) begin
                #1 bus.feat_ready_i = 1'b1;
                #1;
            end else begin
                @(negedge clk);
            end
        end
        if (n >= 200) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0;
        beat_no++;
    endtask

    task automatic send_partial(input int nbeats, input int unsigned v);
        for (int k = 0; k < nbeats; k++) send_beat(v, (k % DIMS) == DIMS - 1);
    endtask

    // Sends the whole window in win[][] and updates the model from its averages.
    task automatic run_window();
        int unsigned s, a, d;
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < DIMS; c++)
                send_beat(win[f][c], c == DIMS - 1);
        for (int c = 0; c < DIMS; c++) begin
            s = 0;
            for (int f = 0; f < NF; f++) s += win[f][c];
            a = s / NF;
            if (m_cal) begin
                m_base[c] = a;
            end else begin
                d = (a > m_base[c]) ? a - m_base[c] : 0;
                if (d > 65535) d = 65535;
                m_vec[c] = OUT_W'(d);
            end
        end
        if (m_cal) m_cal = 0;
        else m_pend = 1;
    endtask

    task automatic fill_const(input int unsigned v);
        for (int f = 0; f < NF; f++) for (int c = 0; c < DIMS; c++) win[f][c] = v;
    endtask

    task automatic fill_alt(input int unsigned a, input int unsigned b);
        for (int f = 0; f < NF; f++) for (int c = 0; c < DIMS; c++) win[f][c] = (f % 2 == 0) ? a : b;
    endtask

    task automatic fill_ramp(input int unsigned b, input int unsigned step);
        for (int f = 0; f < NF; f++) for (int c = 0; c < DIMS; c++) win[f][c] = b + step * c;
    endtask

    task automatic do_cal();
        calibrate = 1'b1;
        @(posedge clk);
        #1;
        calibrate = 1'b0;
        m_cal = 1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_feat_valid"}, bus.feat_valid_o, 0);
        chk({tag, "_feat"}, bus.feat_o, 0);
        chk({tag, "_cal_busy"}, cal_busy, 0);
        chk({tag, "_s_ready"}, bus.s_ready_o, 1);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        for (int c = 0; c < DIMS; c++) m_base[c] = 0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i = '0;
        bus.s_last_i = 1'b0;
        bus.feat_ready_i = 1'b1;
        #1;
        reset_checks("por");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Uncalibrated window of 100s.
        fill_const(100);
        run_window();
        @(negedge clk);
        chk("t2_valid", bus.feat_valid_o, 1);
        chk("t2_feat100", bus.feat_o, {6{16'd100}});
        @(posedge clk);
        #1;

        // Calibrate on 50, then ramp and clamp.
        do_cal();
        fill_const(50);
        run_window();
        @(negedge clk);
        chk("t3_cal_done", cal_busy, 0);
        @(posedge clk);
        #1;
        fill_ramp(50, 10);
        run_window();
        @(negedge clk);
        chk("t3_ramp", bus.feat_o, {16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd0});
        @(posedge clk);
        #1;
        fill_const(40);
        run_window();
        @(negedge clk);
        chk("t3_clamp_valid", bus.feat_valid_o, 1);
        chk("t3_clamp", bus.feat_o, 0);
        @(posedge clk);
        #1;

        // Mid-stream async reset with a pending vector and calibration in progress.
        bus.feat_ready_i = 1'b0;
        fill_const(90);
        run_window();
        do_cal();
        send_partial(10, 5);
        #2;
        rst_n = 1'b0;
        m_pend = 0;
        m_cal = 0;
        m_err = 0;
        for (int c = 0; c < DIMS; c++) m_base[c] = 0;
        #1;
        reset_checks("mid");
        bus.feat_ready_i = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_alt(7, 0);
        run_window();
        @(negedge clk);
        chk("t1_alt3", bus.feat_o, {6{16'd3}});
        @(posedge clk);
        #1;

        // Backpressure across two windows.
        bus.feat_ready_i = 1'b0;
        beat_no = 0;
        stall_log.delete();
        release_after = 3;
        fill_const(10);
        run_window();
        fill_const(20);
        run_window();
        release_after = 0;
        @(negedge clk);
        chk("t4_second", bus.feat_o, {6{16'd20}});
        chk("t4_stall_count", stall_log.size(), 1);
        if (stall_log.size() > 0) chk("t4_stall_beat", stall_log[0], 96);
        @(posedge clk);
        #1;

        // Framing error: s_last on channel 3 of frame 2.
        send_partial(15, 77);
        send_beat(77, 1'b1);
        m_err = 1;
        chk("t5_err_pulse", err, 1);
        @(posedge clk);
        #1;
        m_err = 0;
        chk("t5_err_clear", err, 0);
        fill_const(200);
        run_window();
        @(negedge clk);
        chk("t5_feat200", bus.feat_o, {6{16'd200}});
        @(posedge clk);
        #1;

        // Calibrate on beat 20 of a RUN window; that beat also carries a bad s_last.
        send_partial(19, 1000);
        bus.s_valid_i = 1'b1;
        bus.s_data_i = 16'd1000;
        bus.s_last_i = 1'b1;
        calibrate = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0;
        calibrate = 1'b0;
        m_cal = 1;
        chk("t6_no_err", err, 0);
        chk("t6_busy", cal_busy, 1);
        fill_const(80);
        run_window();
        fill_const(100);
        run_window();
        @(negedge clk);
        chk("t6_feat20", bus.feat_o, {6{16'd20}});
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
